// File: rtl/alu_core.sv
// rtl/alu_core.sv - 8-bit ALU with single-cycle add/and/xor and shift-add multiply
module alu_core #(
    parameter int MUL_STEPS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        done,
    output logic [15:0] result,
    output logic        err,
    output logic        busy
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam int CW = $clog2(MUL_STEPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WAIT_LOW} state_t;

    state_t          state;
    logic [2:0]      op_q;
    logic [7:0]      a_q;
    logic [7:0]      b_q;
    logic [15:0]     mcand;
    logic [7:0]      mplier;
    logic [15:0]     acc;
    logic [CW-1:0]   count;
    logic [8:0]      sum;

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            op_q   <= OP_NOP;
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            mcand  <= 16'h0000;
            mplier <= 8'h00;
            acc    <= 16'h0000;
            count  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            result <= 16'h0000;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= A;
                        b_q  <= B;
                        if (op == OP_MUL) begin
                            state  <= S_MUL;
                            busy   <= 1'b1;
                            count  <= '0;
                            acc    <= 16'h0000;
                            mcand  <= {8'h00, A};
                            mplier <= B;
                        end else if (op != OP_NOP) begin
                            state <= S_EXEC;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_ADD:  result <= {7'b0, sum};
                        OP_AND:  result <= {8'h00, a_q & b_q};
                        OP_XOR:  result <= {8'h00, a_q ^ b_q};
                        default: begin
                            result <= 16'h0000;
                            err    <= 1'b1;
                        end
                    endcase
                    done  <= 1'b1;
                    state <= S_WAIT_LOW;
                end
                S_MUL: begin
                    // Final edge after the last iteration only publishes the product
                    if (count == CW'(MUL_STEPS)) begin
                        result <= acc;
                        done   <= 1'b1;
                        state  <= S_WAIT_LOW;
                    end else begin
                        if (mplier[0])
                            acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + 1'b1;
                    end
                end
                S_WAIT_LOW: begin
                    busy <= 1'b0;
                    if (!start)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - table-driven scoreboard bench for alu_core
module tb_alu_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        done;
    logic [15:0] result;
    logic        err;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [16:0] sb_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        err;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[$];

    alu_core #(.MUL_STEPS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .done(done), .result(result), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [16:0] e;
                e = sb_q.pop_front();
                chk("sb_result", 32'(result), 32'(e[16:1]));
                chk("sb_err", 32'(err), 32'(e[0]));
            end
        end
        if (!reset && err && !done)
            chk("err_without_done", 32'(err), 32'd0);
    end

    task automatic run_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] er, input logic ee, input int lat, input int hold);
        int  n;
        int  bc;
        bit  seen;
        sb_q.push_back({er, ee});
        start = 1'b1; op = o; A = a; B = b;
        n = 0; bc = 0; seen = 0;
        while (n < 30 && !seen) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
            else if (busy) bc++;
            if (n == 1) begin
                op = ~o; A = ~a; B = ~b;
            end
        end
        chk("done_timeout", 32'(seen), 32'd1);
        chk("latency", 32'(n - 1), 32'(lat));
        chk("busy_cycles", 32'(bc), 32'(lat));
        chk("busy_at_done", 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("held_start_no_done", 32'(done), 32'd0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("result_held", 32'(result), 32'(er));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; A = 8'h00; B = 8'h00;
        vecs.push_back('{3'b001, 8'hFF, 8'h01, 16'h0100, 1'b0, 1, 0});
        vecs.push_back('{3'b001, 8'h7F, 8'h01, 16'h0080, 1'b0, 1, 0});
        vecs.push_back('{3'b010, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1, 0});
        vecs.push_back('{3'b011, 8'hF0, 8'h3C, 16'h00CC, 1'b0, 1, 0});
        vecs.push_back('{3'b110, 8'h12, 8'h34, 16'h0000, 1'b1, 1, 0});
        vecs.push_back('{3'b100, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 9, 0});
        vecs.push_back('{3'b101, 8'h01, 8'h01, 16'h0000, 1'b1, 1, 0});
        vecs.push_back('{3'b100, 8'h00, 8'h5A, 16'h0000, 1'b0, 9, 0});
        vecs.push_back('{3'b100, 8'hA5, 8'h3C, 16'h26AC, 1'b0, 9, 0});
        vecs.push_back('{3'b111, 8'hFF, 8'hFF, 16'h0000, 1'b1, 1, 0});
        vecs.push_back('{3'b001, 8'hFF, 8'hFF, 16'h01FE, 1'b0, 1, 5});

        repeat (2) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err,
                    vecs[i].lat, vecs[i].hold);

        // asynchronous reset while idle with a non-zero result on the port
        chk("pre_reset_result", 32'(result), 32'h01FE);
        #2 reset = 1'b1;
        #1;
        chk("idle_rst_result", 32'(result), 32'd0);
        chk("idle_rst_busy", 32'(busy), 32'd0);
        chk("idle_rst_done", 32'(done), 32'd0);
        chk("idle_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // no_op for one edge produces nothing
        start = 1'b1; op = 3'b000; A = 8'd3; B = 8'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("noop_no_done", 32'(done), 32'd0);
            chk("noop_no_busy", 32'(busy), 32'd0);
        end
        run_cmd(3'b001, 8'd3, 8'd4, 16'h0007, 1'b0, 1, 0);

        // reset mid-multiply abandons the operation
        start = 1'b1; op = 3'b100; A = 8'h10; B = 8'h10;
        repeat (4) @(negedge clk);
        chk("mul_busy_before_abort", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        chk("abort_result_after", 32'(result), 32'd0);
        run_cmd(3'b100, 8'd3, 8'd5, 16'h000F, 1'b0, 9, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_core.md
# alu_core

Arithmetic/logic execution unit driven by the ALU bench's bus-functional driver and observed by its command and result monitors. It accepts an operation code and two 8-bit operands under a level `start` / pulse `done` handshake. It returns a 16-bit result: single-cycle for add/and/xor, and multi-cycle (8-step shift-add) for multiply. It is the DUT directly downstream of the stimulus interface.

## Interface
- `MUL_STEPS`, 8: shift-add iterations for multiply. Must equal the operand width.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  command valid; held high by the driver until `done` is seen.
- `op`  in  3  000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101–111 illegal.
- `A`  in  8  operand A, unsigned bit pattern.
- `B`  in  8  operand B, unsigned bit pattern.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  16  result; valid while `done`=1, held until the next completion or reset.
- `err`  out  1  one-cycle pulse coincident with `done` for an illegal op.
- `busy`  out  1  high from command accept until `done`.

## Operation
- FSM states:
  - IDLE: accepts commands.
  - EXEC: single-cycle ops.
  - MUL: iterating.
  - WAIT_LOW: waiting for `start` to drop.
- IDLE, `start`=1 at a rising edge:
  - `op`, `A`, `B` are latched.
  - no_op: no done, no result change; stay IDLE. The driver drops `start` after one edge.
  - add, and, xor, or illegal: go to EXEC.
  - mul: go to MUL. Counter cleared, accumulator 0, multiplicand = A zero-extended to 16 bits, multiplier = B.
- EXEC, next edge:
  - Register `result`: add = {7'b0, A+B (9 bits)}; and = {8'b0, A&B}; xor = {8'b0, A^B}; illegal = 16'h0000 with `err`=1.
  - `done`=1; go to WAIT_LOW.
- MUL, each edge:
  - If multiplier bit 0 is set, add the multiplicand into the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1; increment the counter.
  - After `MUL_STEPS` iterations: register `result` = accumulator (full 16-bit unsigned product, no overflow possible), `done`=1, go to WAIT_LOW.
- WAIT_LOW: go to IDLE on the first edge that samples `start`=0. This prevents a held `start` from re-issuing the same command.
- Operand/op changes while `busy`: ignored (latched copies are used).
- `start` deasserted mid-operation: the operation still completes and pulses `done`.

## Timing
- Reset values: `done`=0, `err`=0, `busy`=0, `result`=16'h0000, state IDLE, counter 0. Reset takes effect immediately and asynchronously, and any in-flight operation is abandoned with no `done`.
- Accept edge t0 = first rising edge in IDLE with `start`=1.
- `busy` is high from t0+ through the cycle in which `done` is high.
- Add/and/xor/illegal: `done` and `result` are registered at edge t0+1, giving latency 1.
- Mul: `done` and `result` are registered at edge t0+1+`MUL_STEPS` (t0+9 by default).
- `done` and `err` are exactly one cycle wide, so the result monitor (sampling on rising edges) sees exactly one result per command.
- Driver timing: it samples `done` on the falling edge and drops `start` before the next rising edge. WAIT_LOW therefore lasts 1 cycle, and a new command can be accepted at the second rising edge after `done`.
- Reset asserted in the same cycle as `done`: reset wins, and `done` reads 0.

## Test plan
- Reset: assert `reset` mid-idle → `done`=0, `err`=0, `busy`=0, `result`=16'h0000 immediately, without waiting for a clock edge.
- Add A=8'hFF, B=8'h01 → at t0+1: `done`=1 for one cycle, `result`=16'h0100. Then A=8'h7F, B=8'h01 → 16'h0080.
- Logic ops:
  - and 8'hF0, 8'h3C → 16'h0030.
  - xor 8'hF0, 8'h3C → 16'h00CC.
  - Illegal op 3'b110 → `result`=16'h0000, `err`=1 together with `done`.
- Mul 8'hFF × 8'hFF → `done` exactly at t0+9, `result`=16'hFE01, `busy` high for 9 cycles. Also 8'h00 × 8'h5A → 16'h0000.
- no_op for one edge, then add 3+4 → no `done` for the no_op; the add is accepted at the next `start` edge, and `result`=16'h0007 one cycle later.
- Abort and handshake:
  - Reset asserted at cycle 4 of mul 8'h10 × 8'h10 → no `done`, `result`=0. A following mul 3 × 5 → 16'h000F.
  - `start` held high for 5 cycles after `done` → no second `done` until `start` drops and rises again.
